// File: rtl/ula_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode encoding and FSM states.
package ula_pkg;

  localparam int unsigned LARGURA_OPCODE = 5;

  localparam logic [LARGURA_OPCODE-1:0] OP_PUSH  = 5'b00010;
  localparam logic [LARGURA_OPCODE-1:0] OP_ADD   = 5'b00100;
  localparam logic [LARGURA_OPCODE-1:0] OP_SUB   = 5'b00101;
  localparam logic [LARGURA_OPCODE-1:0] OP_MUL   = 5'b00110;
  localparam logic [LARGURA_OPCODE-1:0] OP_DIV   = 5'b00111;
  localparam logic [LARGURA_OPCODE-1:0] OP_AND   = 5'b01000;
  localparam logic [LARGURA_OPCODE-1:0] OP_NAND  = 5'b01001;
  localparam logic [LARGURA_OPCODE-1:0] OP_OR    = 5'b01010;
  localparam logic [LARGURA_OPCODE-1:0] OP_XOR   = 5'b01011;
  localparam logic [LARGURA_OPCODE-1:0] OP_CMP   = 5'b01100;
  localparam logic [LARGURA_OPCODE-1:0] OP_NOT   = 5'b01101;
  localparam logic [LARGURA_OPCODE-1:0] OP_IF_EQ = 5'b01111;
  localparam logic [LARGURA_OPCODE-1:0] OP_IF_GT = 5'b10000;
  localparam logic [LARGURA_OPCODE-1:0] OP_IF_LT = 5'b10001;
  localparam logic [LARGURA_OPCODE-1:0] OP_IF_GE = 5'b10010;
  localparam logic [LARGURA_OPCODE-1:0] OP_IF_LE = 5'b10011;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    EXEC_MUL = 2'd1,
    EXEC_DIV = 2'd2,
    RESULT   = 2'd3
  } estado_t;

endpackage

// File: rtl/divisor_iterativo.sv
// Restoring divider, one quotient bit per cycle. Its iteration counter also
// paces the iterative multiplier, so start_i is pulsed for Mul as well.
module divisor_iterativo #(
  parameter int unsigned LARGURA = 16
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [LARGURA-1:0] dividendo_i,
  input  logic [LARGURA-1:0] divisor_i,
  output logic               done_c_o,
  output logic [LARGURA-1:0] quociente_o,
  output logic [LARGURA-1:0] resto_o
);

  localparam int unsigned CW = $clog2(LARGURA);

  logic               ativo_q, ativo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LARGURA-1:0] quo_q, quo_d;
  logic [LARGURA-1:0] rem_q, rem_d;
  logic [LARGURA-1:0] div_q, div_d;
  logic [LARGURA:0]   rem_t;
  logic [LARGURA:0]   sub_t;
  logic               ultimo;

  assign ultimo      = ativo_q & (cnt_q == CW'(LARGURA - 1));
  assign done_c_o    = ultimo;
  assign quociente_o = quo_q;
  assign resto_o     = rem_q;

  // Shift the next dividend bit into the partial remainder, subtract if it fits
  always_comb begin
    ativo_d = ativo_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    rem_t   = {rem_q, quo_q[LARGURA-1]};
    sub_t   = rem_t - {1'b0, div_q};
    if (start_i) begin
      ativo_d = 1'b1;
      cnt_d   = '0;
      quo_d   = dividendo_i;
      rem_d   = '0;
      div_d   = divisor_i;
    end else if (ativo_q) begin
      cnt_d = cnt_q + CW'(1);
      if (!sub_t[LARGURA]) begin
        rem_d = sub_t[LARGURA-1:0];
        quo_d = {quo_q[LARGURA-2:0], 1'b1};
      end else begin
        rem_d = rem_t[LARGURA-1:0];
        quo_d = {quo_q[LARGURA-2:0], 1'b0};
      end
      if (ultimo) ativo_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ativo_q <= 1'b0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
    end else begin
      ativo_q <= ativo_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
    end
  end

endmodule

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU with valid/ready handshakes; Mul is shift-add and Div is restoring.
// Define ULA_MUL_RAPIDA_EN for a single-cycle combinational Mul (EXEC_MUL unused).
module ula_multiciclo #(
  parameter int unsigned LARGURA    = 16,
  parameter int unsigned LARGURA_OP = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valido,
  output logic                  in_pronto,
  input  logic [LARGURA-1:0]    operando1,
  input  logic [LARGURA-1:0]    operando2,
  input  logic [LARGURA_OP-1:0] opcode,
  output logic                  out_valido,
  input  logic                  out_pronto,
  output logic [2*LARGURA-1:0]  resultado,
  output logic                  data_uc,
  output logic                  div_zero
);
  import ula_pkg::*;

  localparam int unsigned LR = 2 * LARGURA;

  estado_t                   estado_q, estado_d;
  logic [LARGURA-1:0]        op1_q, op2_q;
  logic [LARGURA_OPCODE-1:0] opcode_q, opcode_in;
  logic                      out_valido_q, data_uc_q, div_zero_q;
  logic [LR-1:0]             resultado_q;
  logic                      aceita, div_ok, inicia_div, div_done;
  logic [LARGURA-1:0]        quociente, resto;
  logic [LR-1:0]             produto, res_c;
  logic                      uc_c, dz_c, negativo, nulo;

  assign in_pronto  = (estado_q == OCIOSO);
  assign out_valido = out_valido_q;
  assign resultado  = resultado_q;
  assign data_uc    = data_uc_q;
  assign div_zero   = div_zero_q;

  assign opcode_in = LARGURA_OPCODE'(opcode);
  assign aceita    = in_valido & in_pronto;
  assign div_ok    = (opcode_in == OP_DIV) && (operando2 != '0);

`ifdef ULA_MUL_RAPIDA_EN
  assign inicia_div = aceita & div_ok;
  assign produto    = LR'(op1_q) * LR'(op2_q);
`else
  logic          eh_mul;
  logic [LR-1:0] mcand_q, acc_q;
  logic [LARGURA-1:0] mplier_q;

  assign eh_mul     = (opcode_in == OP_MUL);
  assign inicia_div = aceita & (div_ok | eh_mul);
  assign produto    = acc_q;

  // Shift-add multiplier, paced by the divider's iteration counter
  always_ff @(posedge clock) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (aceita) begin
      mcand_q  <= LR'(operando1);
      mplier_q <= operando2;
      acc_q    <= '0;
    end else if (estado_q == EXEC_MUL) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end
`endif

  divisor_iterativo #(.LARGURA(LARGURA)) u_div (
    .clock_i     (clock),
    .reset_i     (reset),
    .start_i     (inicia_div),
    .dividendo_i (operando1),
    .divisor_i   (operando2),
    .done_c_o    (div_done),
    .quociente_o (quociente),
    .resto_o     (resto)
  );

  always_ff @(posedge clock) begin
    if (reset) estado_q <= OCIOSO;
    else       estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO: begin
        if (aceita) begin
          if (div_ok) estado_d = EXEC_DIV;
`ifndef ULA_MUL_RAPIDA_EN
          else if (eh_mul) estado_d = EXEC_MUL;
`endif
          else estado_d = RESULT;
        end
      end
      EXEC_MUL, EXEC_DIV: if (div_done) estado_d = RESULT;
      RESULT:             if (out_valido_q && out_pronto) estado_d = OCIOSO;
      default:            estado_d = OCIOSO;
    endcase
  end

  assign negativo = op1_q[LARGURA-1];
  assign nulo     = (op1_q == '0);

  always_comb begin
    res_c = '0;
    uc_c  = 1'b0;
    dz_c  = 1'b0;
    case (opcode_q)
      OP_PUSH: res_c = {{LARGURA{1'b0}}, op1_q};
      OP_ADD:  res_c = {{(LARGURA-1){1'b0}}, ({1'b0, op1_q} + {1'b0, op2_q})};
      OP_SUB:  res_c = {{(LARGURA-1){1'b0}}, ({1'b0, op1_q} - {1'b0, op2_q})};
      OP_MUL:  res_c = produto;
      OP_DIV: begin
        if (op2_q == '0) begin
          res_c = '1;
          dz_c  = 1'b1;
        end else begin
          res_c = {resto, quociente};
        end
      end
      OP_AND:  res_c = {{LARGURA{1'b0}}, (op1_q & op2_q)};
      OP_NAND: res_c = {{LARGURA{1'b0}}, ~(op1_q & op2_q)};
      OP_OR:   res_c = {{LARGURA{1'b0}}, (op1_q | op2_q)};
      OP_XOR:  res_c = {{LARGURA{1'b0}}, (op1_q ^ op2_q)};
      OP_NOT:  res_c = {{LARGURA{1'b0}}, ~op1_q};
      OP_CMP: begin
        if (op1_q == op2_q)     res_c = '0;
        else if (op1_q > op2_q) res_c = {{(LR-1){1'b0}}, 1'b1};
        else                    res_c = '1;
      end
      OP_IF_EQ: uc_c = nulo;
      OP_IF_GT: uc_c = !negativo && !nulo;
      OP_IF_LT: uc_c = negativo;
      OP_IF_GE: uc_c = !negativo;
      OP_IF_LE: uc_c = negativo || nulo;
      default: ;
    endcase
  end

  // Operand latch on accept; result registered on the first RESULT cycle and held until consumed
  always_ff @(posedge clock) begin
    if (reset) begin
      op1_q        <= '0;
      op2_q        <= '0;
      opcode_q     <= '0;
      out_valido_q <= 1'b0;
      resultado_q  <= '0;
      data_uc_q    <= 1'b0;
      div_zero_q   <= 1'b0;
    end else begin
      if (aceita) begin
        op1_q    <= operando1;
        op2_q    <= operando2;
        opcode_q <= opcode_in;
      end
      if (estado_q == RESULT && !out_valido_q) begin
        out_valido_q <= 1'b1;
        resultado_q  <= res_c;
        data_uc_q    <= uc_c;
        div_zero_q   <= dz_c;
      end else if (estado_q == RESULT && out_pronto) begin
        out_valido_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Self-checking bench for ula_multiciclo: directed cases plus random commands
// checked against an arithmetic reference model (honours ULA_MUL_RAPIDA_EN).
module tb_ula_multiciclo;

  localparam int W = 16;
`ifdef ULA_MUL_RAPIDA_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = W + 1;
`endif

  localparam logic [4:0] PUSH = 5'b00010, ADD = 5'b00100, SUB = 5'b00101, MUL = 5'b00110,
                         DIV = 5'b00111, AND_ = 5'b01000, NAND_ = 5'b01001, OR_ = 5'b01010,
                         XOR_ = 5'b01011, CMP = 5'b01100, NOT_ = 5'b01101, IFEQ = 5'b01111,
                         IFGT = 5'b10000, IFLT = 5'b10001, IFGE = 5'b10010, IFLE = 5'b10011;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valido;
  logic          in_pronto;
  logic [W-1:0]  operando1, operando2;
  logic [4:0]    opcode;
  logic          out_valido;
  logic          out_pronto;
  logic [2*W-1:0] resultado;
  logic          data_uc;
  logic          div_zero;

  int total = 0;
  int bad   = 0;

  ula_multiciclo #(.LARGURA(W), .LARGURA_OP(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valido  (in_valido),
    .in_pronto  (in_pronto),
    .operando1  (operando1),
    .operando2  (operando2),
    .opcode     (opcode),
    .out_valido (out_valido),
    .out_pronto (out_pronto),
    .resultado  (resultado),
    .data_uc    (data_uc),
    .div_zero   (div_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: results from the operation definitions with integer arithmetic
  function automatic void modelo(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [31:0] r, output logic uc, output logic dz,
                                 output int lat);
    int ia, ib, sa, d;
    longint p;
    ia = int'(a);
    ib = int'(b);
    sa = a[W-1] ? ia - 65536 : ia;
    r = '0; uc = 1'b0; dz = 1'b0; lat = 1;
    case (op)
      PUSH:  r = 32'(ia);
      ADD:   r = 32'(ia + ib);
      SUB:   begin d = ia - ib; if (d < 0) d += 131072; r = 32'(d); end
      MUL:   begin p = longint'(ia) * longint'(ib); r = 32'(p); lat = LAT_MUL; end
      DIV:   begin
               if (ib == 0) begin r = 32'hFFFF_FFFF; dz = 1'b1; end
               else begin r = 32'((ia % ib) * 65536 + ia / ib); lat = W + 1; end
             end
      AND_:  r = 32'(ia & ib);
      NAND_: r = 32'(~(ia & ib) & 65535);
      OR_:   r = 32'(ia | ib);
      XOR_:  r = 32'(ia ^ ib);
      NOT_:  r = 32'(~ia & 65535);
      CMP:   r = (ia == ib) ? 32'd0 : (ia > ib) ? 32'd1 : 32'hFFFF_FFFF;
      IFEQ:  uc = (sa == 0);
      IFGT:  uc = (sa > 0);
      IFLT:  uc = (sa < 0);
      IFGE:  uc = (sa >= 0);
      IFLE:  uc = (sa <= 0);
      default: ;
    endcase
  endfunction

  // Issue one command, measure latency, check outputs; optionally stall the consumer
  task automatic rodar(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int espera);
    logic [31:0] er;
    logic        euc, edz;
    int          elat, n;
    modelo(op, a, b, er, euc, edz, elat);
    out_pronto = (espera == 0);
    chk("in_pronto_before", 64'(in_pronto), 64'd1);
    in_valido = 1'b1; opcode = op; operando1 = a; operando2 = b;
    @(posedge clock); #1;
    in_valido = 1'b0;
    opcode = 5'($urandom); operando1 = W'($urandom); operando2 = W'($urandom);
    n = 0;
    while (!out_valido && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk($sformatf("latency op=%b", op), 64'(n), 64'(elat));
    chk($sformatf("resultado op=%b a=%h b=%h", op, a, b), 64'(resultado), 64'(er));
    chk($sformatf("data_uc op=%b a=%h", op, a), 64'(data_uc), 64'(euc));
    chk($sformatf("div_zero op=%b b=%h", op, b), 64'(div_zero), 64'(edz));
    for (int h = 0; h < espera; h++) begin
      in_valido = 1'b1; opcode = ADD; operando1 = 16'd1; operando2 = 16'd1;
      @(posedge clock); #1;
      chk("hold_valido", 64'(out_valido), 64'd1);
      chk("hold_resultado", 64'(resultado), 64'(er));
      chk("hold_in_pronto", 64'(in_pronto), 64'd0);
    end
    in_valido  = 1'b0;
    out_pronto = 1'b1;
    @(posedge clock); #1;
    chk("out_valido_drop", 64'(out_valido), 64'd0);
    chk("in_pronto_after", 64'(in_pronto), 64'd1);
    if (espera > 0) begin
      @(posedge clock); #1;
      chk("ignored_cmd_no_result", 64'(out_valido), 64'd0);
    end
  endtask

  logic [4:0]   ops   [18] = '{PUSH, ADD, SUB, MUL, DIV, AND_, NAND_, OR_, XOR_, CMP, NOT_,
                                 IFEQ, IFGT, IFLT, IFGE, IFLE, 5'b00000, 5'b11111};
  logic [W-1:0] cantos[6]  = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0007};

  initial begin
    logic [W-1:0] a, b;
    reset = 1'b1; in_valido = 1'b0; out_pronto = 1'b1;
    operando1 = '0; operando2 = '0; opcode = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valido", 64'(out_valido), 64'd0);
    chk("rst_resultado", 64'(resultado), 64'd0);
    chk("rst_data_uc", 64'(data_uc), 64'd0);
    chk("rst_div_zero", 64'(div_zero), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_in_pronto", 64'(in_pronto), 64'd1);

    rodar(ADD, 16'hFFFF, 16'h0001, 0);
    rodar(MUL, 16'd300, 16'd200, 0);
    rodar(DIV, 16'd1000, 16'd7, 0);
    rodar(DIV, 16'd5, 16'd0, 0);
    rodar(IFLT, 16'h8000, 16'h0, 0);
    rodar(IFGT, 16'h8000, 16'h0, 0);
    rodar(IFEQ, 16'h0000, 16'h0, 0);
    rodar(IFLE, 16'h0000, 16'h0, 0);
    rodar(SUB, 16'd3, 16'd5, 0);
    rodar(MUL, 16'hFFFF, 16'hFFFF, 0);
    rodar(CMP, 16'd3, 16'd5, 4);

    // Reset in the middle of a division aborts it
    in_valido = 1'b1; opcode = DIV; operando1 = 16'd1000; operando2 = 16'd7;
    @(posedge clock); #1;
    in_valido = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("midrst_out_valido", 64'(out_valido), 64'd0);
    chk("midrst_resultado", 64'(resultado), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("midrst_in_pronto", 64'(in_pronto), 64'd1);
    repeat (20) @(posedge clock);
    #1;
    chk("midrst_no_result", 64'(out_valido), 64'd0);
    rodar(ADD, 16'd2, 16'd3, 0);

    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 3) == 0) ? cantos[$urandom_range(0, 5)] : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? cantos[$urandom_range(0, 5)] : W'($urandom);
      rodar(ops[$urandom_range(0, 17)], a, b, ($urandom_range(0, 7) == 0) ? 2 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
